tremolo_mod: RTL and testbench

Amplitude-modulation (tremolo) stage directly downstream of the cosine NCO. Consumes the NCO's signed waveform sample `wav` and scales a streaming audio sample by a depth-weighted gain derived from it. Sits in the effects chain between the audio input stream and the next effect or DAC path. Uses a 3-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/tremolo_pkg.sv | 15 +
 rtl/tremolo_gain.sv | 35 +++
 rtl/tremolo_mod.sv | 62 ++++++
 tb/tb_tremolo_mod.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tremolo_pkg.sv
// Shared widths, constants and types for the tremolo amplitude-modulation stage.
package tremolo_pkg;

  localparam int WIDTH       = 24;
  localparam int DEPTH_WIDTH = 8;
  localparam int GAIN_WIDTH  = WIDTH + 1;
  localparam int PROD_WIDTH  = WIDTH + GAIN_WIDTH;

  typedef logic signed [WIDTH-1:0] sample_t;
  typedef logic [GAIN_WIDTH-1:0]   gain_t;

  // 1.0 in unsigned Q1.24
  localparam gain_t UNITY_GAIN = {1'b1, {WIDTH{1'b0}}};

endpackage

// File: rtl/tremolo_gain.sv
// Two-stage registered gain: depth*inverse-modulator product, then G = 1.0 - product/256.
module tremolo_gain
  import tremolo_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   adv,
  input  logic [WIDTH-1:0]       wav,
  input  logic [DEPTH_WIDTH-1:0] depth,
  input  logic                   en,
  output gain_t                  gain
);

  logic [WIDTH-1:0]             mod_ob;
  logic [WIDTH-1:0]             mod_inv;
  logic [WIDTH+DEPTH_WIDTH-1:0] prod_q;
  logic                         en_q;

  // Offset-binary modulator; its inverse (2^24-1 - m) is just the bitwise complement.
  assign mod_ob  = {~wav[WIDTH-1], wav[WIDTH-2:0]};
  assign mod_inv = ~mod_ob;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      en_q   <= 1'b0;
      gain   <= UNITY_GAIN;
    end else if (adv) begin
      prod_q <= {{WIDTH{1'b0}}, depth} * {{DEPTH_WIDTH{1'b0}}, mod_inv};
      en_q   <= en;
      gain   <= en_q ? gain_t'(UNITY_GAIN - gain_t'(prod_q >> DEPTH_WIDTH)) : UNITY_GAIN;
    end
  end

endmodule

// File: rtl/tremolo_mod.sv
// Tremolo stage: 3-stage pipeline scaling audio by a depth-weighted gain taken from the NCO waveform.
module tremolo_mod
  import tremolo_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DEPTH_WIDTH-1:0] depth,
  input  logic [WIDTH-1:0]       wav,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data
);

  // Handshake: a word moves on a port when valid && ready at a rising edge.
  // The whole pipe stalls together; s_ready is the advance term itself.
  logic adv;
  assign adv     = !m_valid || m_ready;
  assign s_ready = adv;

  logic                          v1, v2;
  sample_t                       d1, d2;
  gain_t                         gain;
  logic signed [PROD_WIDTH-1:0]  d_ext, g_ext, prod;

  tremolo_gain u_gain (
    .clk   (clk),
    .rst   (rst),
    .adv   (adv),
    .wav   (wav),
    .depth (depth),
    .en    (en),
    .gain  (gain)
  );

  assign d_ext = {{GAIN_WIDTH{d2[WIDTH-1]}}, d2};
  assign g_ext = {{WIDTH{1'b0}}, gain};
  assign prod  = d_ext * g_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      d1      <= '0;
      d2      <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (adv) begin
      v1      <= s_valid;
      d1      <= s_data;
      v2      <= v1;
      d2      <= d1;
      m_valid <= v2;
      // Arithmetic shift floors toward -inf; G <= 1.0 so the result always fits.
      m_data  <= WIDTH'(prod >>> WIDTH);
    end
  end

endmodule

// File: tb/tb_tremolo_mod.sv
// Bench for tremolo_mod: vector table, latency/backpressure/reset sequences, random stream.
module tb_tremolo_mod;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  depth;
  logic [23:0] wav;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;

  always #5 clk = ~clk;

  tremolo_mod dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .depth   (depth),
    .wav     (wav),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  typedef struct {
    logic [23:0] s;
    logic [23:0] wav;
    logic [7:0]  depth;
    logic        en;
    logic [23:0] exp;
  } vec_t;

  vec_t        vecs[8];
  logic [23:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        stalled = 1'b0;
  logic [23:0] held;
  logic        rnd_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: G = 2^24 - ((depth * (2^24-1-m)) >> 8), out = floor(s*G / 2^24).
  function automatic logic [23:0] model(input logic [23:0] s, input logic [23:0] w,
                                        input logic [7:0] d, input logic e);
    longint m, i, g, p;
    m = longint'(w ^ 24'h800000);
    i = 64'hFFFFFF - m;
    g = e ? (64'd1 << 24) - ((longint'(d) * i) >> 8) : (64'd1 << 24);
    p = longint'($signed(s)) * g;
    p = p >>> 24;
    return p[23:0];
  endfunction

  task automatic send(input logic [23:0] s, input logic [23:0] w, input logic [7:0] d,
                      input logic e, input logic [23:0] exp);
    logic done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = s;
    wav     = w;
    depth   = d;
    en      = e;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (s_ready) begin
        exp_q.push_back(exp);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("send_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: scoreboard pop on transfer, hold-stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) begin
        check("stall_m_valid", {31'd0, m_valid}, 32'd1);
        check("stall_m_data", {8'd0, m_data}, {8'd0, held});
      end
      if (m_valid && !m_ready) begin
        check("stall_s_ready", {31'd0, s_ready}, 32'd0);
        stalled <= 1'b1;
        held    <= m_data;
      end else begin
        stalled <= 1'b0;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", {8'd0, m_data}, 32'hFFFFFFFF);
        else check("out_data", {8'd0, m_data}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; wav = '0; depth = '0; en = 1'b0; m_ready = 1'b1;
    vecs[0] = '{24'h100000, 24'h000000, 8'd0,   1'b1, 24'h100000};
    vecs[1] = '{24'h400000, 24'h800000, 8'd255, 1'b1, 24'h004000};
    vecs[2] = '{24'hC00000, 24'h800000, 8'd255, 1'b1, 24'hFFBFFF};
    vecs[3] = '{24'h7FFFFF, 24'h7FFFFF, 8'd255, 1'b1, 24'h7FFFFF};
    vecs[4] = '{24'h123456, 24'h800000, 8'd255, 1'b0, 24'h123456};
    vecs[5] = '{24'h200000, 24'h000000, 8'd128, 1'b1, 24'h180000};
    vecs[6] = '{24'hE00000, 24'h000000, 8'd128, 1'b1, 24'hE7FFFF};
    vecs[7] = '{24'h800000, 24'h800000, 8'd255, 1'b1, 24'hFF7FFF};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_m_valid", {31'd0, m_valid}, 32'd0);
    check("reset_m_data", {8'd0, m_data}, 32'd0);
    check("reset_s_ready", {31'd0, s_ready}, 32'd1);

    // Latency: m_valid rises on the third edge counting the transfer edge.
    send(vecs[0].s, vecs[0].wav, vecs[0].depth, vecs[0].en, vecs[0].exp);
    check("lat_edge1_valid", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_edge2_valid", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_edge3_valid", {31'd0, m_valid}, 32'd1);
    check("lat_edge3_data", {8'd0, m_data}, 32'h00100000);
    drain();

    for (int v = 0; v < 8; v++) send(vecs[v].s, vecs[v].wav, vecs[v].depth, vecs[v].en, vecs[v].exp);
    drain();

    // Backpressure: 10 incrementing samples, m_ready low for 5 cycles mid-stream.
    fork
      begin
        for (int v = 0; v < 10; v++) send(24'h010000 + 24'(v), 24'h000000, 8'd0, 1'b1, 24'h010000 + 24'(v));
      end
      begin
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain();

    // Reset with three samples in flight.
    m_ready = 1'b0;
    send(24'h111111, 24'h000000, 8'd0, 1'b1, 24'h111111);
    send(24'h222222, 24'h000000, 8'd0, 1'b1, 24'h222222);
    send(24'h333333, 24'h000000, 8'd0, 1'b1, 24'h333333);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    check("midrst_m_data", {8'd0, m_data}, 32'd0);
    m_ready = 1'b1;
    send(24'h0ABCDE, 24'h000000, 8'd0, 1'b1, 24'h0ABCDE);
    drain();

    // Random stream with random downstream stalls.
    rnd_done = 1'b0;
    fork
      begin
        for (int v = 0; v < 24; v++) begin
          logic [23:0] rs, rw;
          logic [7:0]  rd;
          logic        re;
          rs = 24'($urandom_range(0, 24'hFFFFFF));
          rw = 24'($urandom_range(0, 24'hFFFFFF));
          rd = 8'($urandom_range(0, 255));
          re = ($urandom_range(0, 7) != 0);
          send(rs, rw, rd, re, model(rs, rw, rd, re));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
